bitplane_streamer: RTL and testbench
====================================

# bitplane_streamer

Parametrised, sequential successor to the combinational vector-to-bit-plane transpose in the systolic array feed path. It accepts packed vectors of `LANES` elements, each `DW` bits wide, through a valid/ready handshake and buffers up to two of them. It then streams each vector out as `DW` bit-planes, one plane per cycle, in either MSB-first or LSB-first order. It sits between the operand memory and the bit-serial PE row inputs of the array.

## Interface
- `LANES`, 16, number of elements per vector; also the plane width (≥1).
- `DW`, 8, element width; also the number of planes per vector (≥1).
- `MSB_FIRST`, 1, plane order: 1 emits bit `DW-1` down to bit 0; 0 emits bit 0 up to bit `DW-1`.
- `IW`, max(1, $clog2(DW)), width of the plane index (derived localparam).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_data` holds a vector.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_data`  in  LANES*DW  element i = `in_data[i*DW +: DW]`.
- `out_valid`  out  1  `out_plane` is valid.
- `out_ready`  in  1  consumer takes the plane this cycle.
- `out_plane`  out  LANES  `out_plane[i]` = bit `out_idx` of element i of the head vector.
- `out_idx`  out  IW  bit position carried by the current plane.
- `out_first`  out  1  current plane is the first of its vector.
- `out_last`  out  1  current plane is the last of its vector.

## Operation
- Storage: a two-entry FIFO of full vectors (head/tail pointer plus `count` in 0..2), and a plane counter `pc` in 0..DW-1.
- Push: `in_valid && in_ready` writes `in_data` into the tail entry.
- `in_ready` = (`count != 2`) && !`rst`. There is no same-cycle pass-through when full, so a pop in the same cycle does not raise `in_ready`.
- `out_valid` = (`count != 0`).
- `out_idx` = `MSB_FIRST ? DW-1-pc : pc`.
- `out_plane` is combinational from the head entry and `out_idx`.
- `out_first` = (`pc == 0`) && `out_valid`; `out_last` = (`pc == DW-1`) && `out_valid`.
- Plane transfer (`out_valid && out_ready`):
  - if `pc == DW-1`: set `pc` to 0 and pop the head entry;
  - else: increment `pc`.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- When `out_ready` is low, `out_plane`, `out_idx`, `out_first` and `out_last` hold steady. They may change only after a transfer.
- `DW == 1`: every plane has `out_first` and `out_last` both high, and each transfer pops one vector.
- Reset (at any time, including mid-vector) has the following effects, and any partially streamed vector is discarded:
  - `count` = 0, both pointers = 0, `pc` = 0;
  - both entries cleared to 0;
  - `out_valid` = 0, `out_plane` = 0, `out_first` = `out_last` = 0, `in_ready` = 0 while `rst` is high;
  - `out_idx` = reset value of the `pc` mapping (`DW-1` when `MSB_FIRST`, else 0).

## Timing
- Latency: a vector accepted at edge t into an empty block gives `out_valid` = 1 with its first plane in the cycle after t.
- Throughput: `DW` cycles per vector with `out_ready` held high.
  - The first plane of the next vector follows the last plane of the current one with no bubble, provided the next vector was pushed by the edge that pops the current one.
- First push is possible in the first cycle after `rst` deasserts.
- All outputs are registered-state-derived (no combinational path from `in_*` to `out_*`). `out_*` does depend combinationally on state only.

## Test plan
Default parameters unless stated; element i = i for i = 0..15.
- Single vector, `out_ready` = 1, MSB-first. Required `out_plane` sequence: 0x0000 ×4 (idx 7..4), 0xFF00 (idx 3), 0xF0F0, 0xCCCC, 0xAAAA. `out_first` on idx 7, `out_last` on idx 0, then `out_valid` drops.
- Same vector with `MSB_FIRST` = 0. Required sequence: 0xAAAA, 0xCCCC, 0xF0F0, 0xFF00, then 0x0000 ×4, with idx 0..7.
- Three vectors offered back-to-back (element i = i, 15−i, 0xFF) with `out_ready` = 1.
  - `in_ready` goes low after two pushes.
  - The third push is accepted on the cycle after the first vector's last plane.
  - 24 planes are emitted with no bubble; the last vector gives 0xFFFF ×8.
- Random `out_ready` stalls (~50%) over 200 random vectors. Required: outputs are stable during stalls, and the reconstructed elements match the inputs exactly.
- `rst` pulsed during plane idx 4 of a full buffer. Required next cycle: `out_valid` = 0, `out_plane` = 0, `in_ready` = 1 after release. A new vector then streams from `out_first`.
- `DW` = 1, `LANES` = 4, input 4'b1010. Required: one plane 4'b1010 with `out_first` = `out_last` = 1, and a pop every transfer.

Source files
------------

// File: rtl/bitplane_streamer.sv
// Two-entry vector buffer that streams each LANES x DW vector out as DW bit-planes,
// one plane per cycle, MSB-first or LSB-first.
module bitplane_streamer #(
    parameter int LANES     = 16,
    parameter int DW        = 8,
    parameter bit MSB_FIRST = 1,
    localparam int IW       = (DW > 1) ? $clog2(DW) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_plane,
    output logic [IW-1:0]         out_idx,
    output logic                  out_first,
    output logic                  out_last
);

    localparam logic [IW-1:0] PC_MAX = IW'(DW - 1);

    logic [LANES*DW-1:0] mem_reg [2];
    logic                wr_ptr_reg;
    logic                rd_ptr_reg;
    logic [1:0]          count_reg;
    logic [1:0]          count_next;
    logic [IW-1:0]       pc_reg;
    logic [IW-1:0]       pc_next;
    logic [LANES*DW-1:0] head_vec;
    logic                push;
    logic                xfer;
    logic                pop;

    // Full means full: a pop in the same cycle does not open the input.
    assign in_ready  = (count_reg != 2'd2) && !rst;
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (pc_reg == PC_MAX);

    assign out_idx   = MSB_FIRST ? (PC_MAX - pc_reg) : pc_reg;
    assign out_first = out_valid && (pc_reg == '0);
    assign out_last  = out_valid && (pc_reg == PC_MAX);
    assign head_vec  = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DW-1:0] elem;
            assign elem          = head_vec[gi*DW +: DW];
            assign out_plane[gi] = elem[out_idx];
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        pc_next    = pc_reg;
        if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
        if (xfer) begin
            pc_next = pop ? '0 : pc_reg + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= '0;
            pc_reg     <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= in_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
            pc_reg    <= pc_next;
        end
    end

endmodule

// File: tb/tb_bitplane_streamer.sv
// Directed and table-driven bench for bitplane_streamer: MSB/LSB ordering, back-to-back
// flow, random stalls with reconstruction, mid-vector reset and the single-plane case.
module tb_bitplane_streamer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic         m_in_ready, m_out_valid, m_first, m_last;
    logic [15:0]  m_out_plane;
    logic [2:0]   m_out_idx;
    logic         l_in_ready, l_out_valid, l_first, l_last;
    logic [15:0]  l_out_plane;
    logic [2:0]   l_out_idx;

    logic         d_in_valid, d_out_ready;
    logic [3:0]   d_in_data;
    logic         d_in_ready, d_out_valid, d_first, d_last;
    logic [3:0]   d_out_plane;
    logic [0:0]   d_out_idx;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] plane;
        logic [2:0]  idx;
        logic        first;
        logic        last;
    } exp_t;

    exp_t         tm [8];
    exp_t         tl [8];
    logic [127:0] vecs [3];
    logic [127:0] sb [$];
    logic [127:0] recon, want;
    logic [22:0]  held_val;
    logic         held, fired;
    int           pushed, planes, push2_cyc, push3_cyc, last_v0_cyc, first_cyc, last_cyc;
    int           sent, recv, rpc, cyc;

    always #5 clk = ~clk;

    bitplane_streamer #(.LANES(16), .DW(8), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_plane(m_out_plane),
        .out_idx(m_out_idx), .out_first(m_first), .out_last(m_last)
    );

    bitplane_streamer #(.LANES(16), .DW(8), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
        .out_valid(l_out_valid), .out_ready(out_ready), .out_plane(l_out_plane),
        .out_idx(l_out_idx), .out_first(l_first), .out_last(l_last)
    );

    bitplane_streamer #(.LANES(4), .DW(1), .MSB_FIRST(1)) u_dw1 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_plane(d_out_plane),
        .out_idx(d_out_idx), .out_first(d_first), .out_last(d_last)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] plane_of(input logic [127:0] v, input int b);
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = v[i*8 + b];
        return p;
    endfunction

    // Streams one vector already pushed and compares every plane against the table.
    task automatic run_table(input string tag, input bit with_lsb);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_msb_plane"}, {m_out_valid, m_out_plane, m_out_idx, m_first, m_last},
                {1'b1, tm[k].plane, tm[k].idx, tm[k].first, tm[k].last});
            if (with_lsb)
                chk({tag, "_lsb_plane"}, {l_out_valid, l_out_plane, l_out_idx, l_first, l_last},
                    {1'b1, tl[k].plane, tl[k].idx, tl[k].first, tl[k].last});
            $display("%s plane %0d: msb %h idx %0d  lsb %h idx %0d", tag, k,
                     m_out_plane, m_out_idx, l_out_plane, l_out_idx);
            @(negedge clk);
        end
        chk({tag, "_msb_drained"}, m_out_valid, 1'b0);
        if (with_lsb) chk({tag, "_lsb_drained"}, l_out_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tm[0] = '{16'h0000, 3'd7, 1'b1, 1'b0};
        tm[1] = '{16'h0000, 3'd6, 1'b0, 1'b0};
        tm[2] = '{16'h0000, 3'd5, 1'b0, 1'b0};
        tm[3] = '{16'h0000, 3'd4, 1'b0, 1'b0};
        tm[4] = '{16'hFF00, 3'd3, 1'b0, 1'b0};
        tm[5] = '{16'hF0F0, 3'd2, 1'b0, 1'b0};
        tm[6] = '{16'hCCCC, 3'd1, 1'b0, 1'b0};
        tm[7] = '{16'hAAAA, 3'd0, 1'b0, 1'b1};
        tl[0] = '{16'hAAAA, 3'd0, 1'b1, 1'b0};
        tl[1] = '{16'hCCCC, 3'd1, 1'b0, 1'b0};
        tl[2] = '{16'hF0F0, 3'd2, 1'b0, 1'b0};
        tl[3] = '{16'hFF00, 3'd3, 1'b0, 1'b0};
        tl[4] = '{16'h0000, 3'd4, 1'b0, 1'b0};
        tl[5] = '{16'h0000, 3'd5, 1'b0, 1'b0};
        tl[6] = '{16'h0000, 3'd6, 1'b0, 1'b0};
        tl[7] = '{16'h0000, 3'd7, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            vecs[0][i*8 +: 8] = 8'(i);
            vecs[1][i*8 +: 8] = 8'(15 - i);
            vecs[2][i*8 +: 8] = 8'hFF;
        end

        // Reset state
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_msb", {m_out_valid, m_in_ready, m_out_plane, m_out_idx, m_first, m_last},
            {1'b0, 1'b0, 16'h0000, 3'd7, 1'b0, 1'b0});
        chk("reset_lsb_idx", {l_out_valid, l_out_idx}, {1'b0, 3'd0});
        chk("reset_dw1", {d_out_valid, d_in_ready, d_out_idx}, {1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        #1;
        chk("ready_after_reset", m_in_ready, 1'b1);

        // Single vector, both plane orders
        in_valid = 1'b1; in_data = vecs[0]; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        run_table("single", 1'b1);

        // Three back-to-back vectors, out_ready held high
        pushed = 0; planes = 0; push2_cyc = -10; push3_cyc = -1; last_v0_cyc = -1;
        first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in_valid = (pushed < 3);
            in_data  = (pushed < 3) ? vecs[pushed] : '0;
            if (c == push2_cyc + 1) chk("b2b_full_ready_low", m_in_ready, 1'b0);
            if (in_valid && m_in_ready) begin
                if (pushed == 1) push2_cyc = c;
                if (pushed == 2) push3_cyc = c;
                $display("b2b push %0d at cycle %0d", pushed, c);
                pushed++;
            end
            if (m_out_valid) begin
                if (planes < 24) begin
                    chk("b2b_plane", {m_out_plane, m_out_idx, m_first, m_last},
                        {plane_of(vecs[planes/8], 7 - planes%8), 3'(7 - planes%8),
                         planes%8 == 0, planes%8 == 7});
                    if (planes >= 16) chk("b2b_ff_plane", m_out_plane, 16'hFFFF);
                end else begin
                    chk("b2b_extra_plane", m_out_valid, 1'b0);
                end
                if (planes == 7) last_v0_cyc = c;
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                planes++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_plane_count", planes, 24);
        chk("b2b_third_push_cycle", push3_cyc, last_v0_cyc + 1);
        chk("b2b_no_bubble", last_cyc - first_cyc, 23);
        $display("b2b: %0d planes over cycles %0d..%0d", planes, first_cyc, last_cyc);

        // Random stalls with reconstruction
        sent = 0; recv = 0; rpc = 0; cyc = 0; held = 1'b0; fired = 1'b0; held_val = '0;
        in_valid = 1'b0;
        while (recv < 200 && cyc < 10000) begin
            @(negedge clk);
            cyc++;
            if (held)
                chk("stall_hold", {m_out_valid, m_out_plane, m_out_idx, m_first, m_last}, held_val);
            if (fired) in_valid = 1'b0;
            if (!in_valid && sent < 200) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            fired = in_valid && m_in_ready;
            if (fired) begin
                sb.push_back(in_data);
                sent++;
            end
            out_ready = 1'($urandom_range(0, 1));
            if (m_out_valid && out_ready) begin
                if (m_out_idx != 3'(7 - rpc) || m_first != (rpc == 0) || m_last != (rpc == 7))
                    chk("rand_plane_pos", {m_out_idx, m_first, m_last},
                        {3'(7 - rpc), rpc == 0, rpc == 7});
                for (int i = 0; i < 16; i++) recon[i*8 + (7 - rpc)] = m_out_plane[i];
                if (rpc == 7) begin
                    want = (sb.size() > 0) ? sb.pop_front() : '0;
                    chk("rand_reconstruct", recon, want);
                    $display("rand vec %0d: %h", recon_dummy_idx(recv), recon);
                    recv++;
                    rpc = 0;
                end else begin
                    rpc++;
                end
            end
            held     = m_out_valid && !out_ready;
            held_val = {m_out_valid, m_out_plane, m_out_idx, m_first, m_last};
        end
        if (fired) in_valid = 1'b0;
        in_valid = 1'b0;
        chk("rand_received", recv, 200);

        // Drain, fill both entries, then reset during plane idx 4
        out_ready = 1'b1;
        for (int n = 0; n < 20 && m_out_valid; n++) @(negedge clk);
        chk("drain_empty", m_out_valid, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = vecs[0];
        @(negedge clk);
        in_data = vecs[1];
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_ready_low", m_in_ready, 1'b0);
        out_ready = 1'b1;
        for (int n = 0; n < 10 && m_out_idx != 3'd4; n++) @(negedge clk);
        chk("reach_idx4", {m_out_valid, m_out_idx}, {1'b1, 3'd4});
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {m_out_valid, m_in_ready, m_out_plane, m_out_idx, m_first, m_last},
            {1'b0, 1'b0, 16'h0000, 3'd7, 1'b0, 1'b0});
        rst = 1'b0;
        #1;
        chk("midreset_ready_release", m_in_ready, 1'b1);
        in_valid = 1'b1; in_data = vecs[0];
        @(negedge clk);
        in_valid = 1'b0;
        run_table("after_reset", 1'b0);

        // DW = 1: each transfer pops one vector
        d_out_ready = 1'b1; d_in_valid = 1'b1; d_in_data = 4'b1010;
        @(negedge clk);
        d_in_data = 4'b0101;
        chk("dw1_first", {d_out_valid, d_out_plane, d_out_idx, d_first, d_last},
            {1'b1, 4'b1010, 1'b0, 1'b1, 1'b1});
        $display("dw1 plane %b first %b last %b", d_out_plane, d_first, d_last);
        @(negedge clk);
        d_in_valid = 1'b0;
        chk("dw1_second", {d_out_valid, d_out_plane, d_first, d_last},
            {1'b1, 4'b0101, 1'b1, 1'b1});
        $display("dw1 plane %b first %b last %b", d_out_plane, d_first, d_last);
        @(negedge clk);
        chk("dw1_empty", d_out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic int recon_dummy_idx(input int n);
        return n;
    endfunction

endmodule
